// File: rtl/alu_sequencer_pkg.sv
// Shared ALU / sequencer types: ALU op codes, sequencer commands and FSM states.
package alu_sequencer_pkg;

  // Op codes understood by the shared-bus ALU.
  typedef enum logic [2:0] {
    ALU_NOP      = 3'd0,
    ALU_WRITE_R0 = 3'd1,
    ALU_WRITE_R1 = 3'd2,
    ALU_ADD      = 3'd3,
    ALU_SUB      = 3'd4,
    ALU_INC      = 3'd5
  } alu_op_t;

  // Commands accepted on the sequencer request port.
  typedef enum logic [1:0] {
    CMD_ADD  = 2'd0,
    CMD_SUB  = 2'd1,
    CMD_INC  = 2'd2,
    CMD_RSVD = 2'd3
  } seq_cmd_t;

  // Sequencer FSM states.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR0  = 3'd1,
    S_WR1  = 3'd2,
    S_TURN = 3'd3,
    S_EXEC = 3'd4,
    S_DONE = 3'd5
  } seq_state_t;

  // ALU operation issued in EXEC for a given command.
  function automatic alu_op_t exec_op(input seq_cmd_t cmd);
    case (cmd)
      CMD_ADD: exec_op = ALU_ADD;
      CMD_SUB: exec_op = ALU_SUB;
      CMD_INC: exec_op = ALU_INC;
      default: exec_op = ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Shared-bus ALU: captures R0/R1 from the bus on write ops and drives the
// result back onto the bus combinationally while an arithmetic op is presented.
module alu
  import alu_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             n_reset,
  input  alu_op_t          op,
  inout  wire  [WIDTH-1:0] bus
);

  logic [WIDTH-1:0] r0_q;
  logic [WIDTH-1:0] r1_q;
  logic [WIDTH-1:0] result;
  logic             drive_en;

  // Operand registers loaded from the bus on write ops.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r0_q <= '0;
      r1_q <= '0;
    end else begin
      if (op == ALU_WRITE_R0) r0_q <= bus;
      if (op == ALU_WRITE_R1) r1_q <= bus;
    end
  end

  // Result computation, modulo 2^WIDTH; the bus is driven only for result ops.
  always_comb begin
    result   = '0;
    drive_en = 1'b0;
    case (op)
      ALU_ADD: begin result = r0_q + r1_q;          drive_en = 1'b1; end
      ALU_SUB: begin result = r0_q - r1_q;          drive_en = 1'b1; end
      ALU_INC: begin result = r0_q + WIDTH'(1);     drive_en = 1'b1; end
      default: ;
    endcase
  end

  assign bus = drive_en ? result : {WIDTH{1'bz}};

endmodule

// File: rtl/tri_buf.sv
// Tri-state bus driver: drives data onto the bus while rw is high, otherwise releases it.
module tri_buf #(
  parameter int WIDTH = 8
) (
  input  logic             rw,
  input  logic [WIDTH-1:0] data,
  inout  wire  [WIDTH-1:0] bus
);

  assign bus = rw ? data : {WIDTH{1'bz}};

endmodule

// File: rtl/alu_sequencer.sv
// ALU sequencer: takes one arithmetic request, writes R0/R1 over the shared bus,
// optionally idles for bus turnaround, executes, captures the ALU result and
// presents it on the response port until consumed.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int TURNAROUND = 0
) (
  input  logic             clock,
  input  logic             n_reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_cmd,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output alu_op_t          op,
  inout  wire  [WIDTH-1:0] bus,
  output logic             busy
);

  // Counter preload: TURN lasts TURNAROUND cycles, leaving when the count hits zero.
  localparam logic [1:0] TURN_LOAD = (TURNAROUND > 0) ? 2'(TURNAROUND - 1) : 2'd0;
  // State following the last operand write.
  localparam seq_state_t POST_WRITE = (TURNAROUND > 0) ? S_TURN : S_EXEC;

  seq_state_t       state_q, state_d;
  seq_cmd_t         cmd_q, cmd_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       turn_cnt_q, turn_cnt_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  alu_op_t          op_q, op_d;
  logic             drv_en_q, drv_en_d;
  logic [WIDTH-1:0] drv_data_q, drv_data_d;

  // State, request latches, response and registered bus controls.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= S_IDLE;
      cmd_q      <= CMD_ADD;
      a_q        <= '0;
      b_q        <= '0;
      turn_cnt_q <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      op_q       <= ALU_NOP;
      drv_en_q   <= 1'b0;
      drv_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      a_q        <= a_d;
      b_q        <= b_d;
      turn_cnt_q <= turn_cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      op_q       <= op_d;
      drv_en_q   <= drv_en_d;
      drv_data_q <= drv_data_d;
    end
  end

  // Next-state logic; op and bus drive are derived from the next state so
  // they are valid registered outputs throughout the state they belong to.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    a_d        = a_q;
    b_d        = b_q;
    turn_cnt_d = turn_cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    op_d       = ALU_NOP;
    drv_en_d   = 1'b0;
    drv_data_d = '0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          cmd_d = seq_cmd_t'(req_cmd);
          a_d   = req_a;
          b_d   = req_b;
          if (cmd_d == CMD_RSVD) begin
            // Reserved command: answer immediately with an error, no bus traffic.
            state_d    = S_DONE;
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
          end else begin
            state_d = S_WR0;
          end
        end
      end
      S_WR0:  state_d = (cmd_q == CMD_INC) ? POST_WRITE : S_WR1;
      S_WR1:  state_d = POST_WRITE;
      S_TURN: begin
        if (turn_cnt_q == 2'd0) state_d = S_EXEC;
        else                    turn_cnt_d = turn_cnt_q - 2'd1;
      end
      S_EXEC: begin
        // ALU is driving its result during EXEC; capture it at the closing edge.
        rsp_data_d = bus;
        rsp_err_d  = 1'b0;
        state_d    = S_DONE;
      end
      S_DONE: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_TURN && state_q != S_TURN) turn_cnt_d = TURN_LOAD;

    case (state_d)
      S_WR0: begin op_d = ALU_WRITE_R0; drv_en_d = 1'b1; drv_data_d = a_d; end
      S_WR1: begin op_d = ALU_WRITE_R1; drv_en_d = 1'b1; drv_data_d = b_d; end
      S_EXEC: op_d = exec_op(cmd_d);
      default: ;
    endcase
  end

  tri_buf #(.WIDTH(WIDTH)) u_tri_buf (
    .rw   (drv_en_q),
    .data (drv_data_q),
    .bus  (bus)
  );

  assign req_ready = n_reset && (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign op        = op_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench: two sequencers (TURNAROUND 0 and 2), each paired with a real ALU on its own bus.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic       clock = 1'b0;
  logic       n_reset = 1'b0;
  logic [1:0] req_cmd = 2'd0;
  logic [7:0] req_a = 8'd0;
  logic [7:0] req_b = 8'd0;
  logic       rsp_ready = 1'b0;

  logic       req_valid0 = 1'b0, req_ready0, rsp_valid0, rsp_err0, busy0;
  logic [7:0] rsp_data0;
  alu_op_t    op0;
  wire  [7:0] bus0;

  logic       req_valid2 = 1'b0, req_ready2, rsp_valid2, rsp_err2, busy2;
  logic [7:0] rsp_data2;
  alu_op_t    op2;
  wire  [7:0] bus2;

  int errors = 0;
  int checks = 0;

  always #1 clock = ~clock;

  alu_sequencer #(.WIDTH(8), .TURNAROUND(0)) dut0 (
    .clock(clock), .n_reset(n_reset), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_cmd(req_cmd), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid0),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data0), .rsp_err(rsp_err0), .op(op0),
    .bus(bus0), .busy(busy0)
  );
  alu #(.WIDTH(8)) alu0 (.clock(clock), .n_reset(n_reset), .op(op0), .bus(bus0));

  alu_sequencer #(.WIDTH(8), .TURNAROUND(2)) dut2 (
    .clock(clock), .n_reset(n_reset), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_cmd(req_cmd), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid2),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data2), .rsp_err(rsp_err2), .op(op2),
    .bus(bus2), .busy(busy2)
  );
  alu #(.WIDTH(8)) alu2 (.clock(clock), .n_reset(n_reset), .op(op2), .bus(bus2));

  task automatic nedge();
    @(negedge clock);
  endtask

  task automatic test_reset();
    nedge(); nedge();
    checks++; if (op0 !== ALU_NOP) begin errors++; $display("FAIL rst_op: got %0d want %0d", op0, ALU_NOP); end
    checks++; if (dut0.drv_en_q !== 1'b0) begin errors++; $display("FAIL rst_drv_en: got %0b want 0", dut0.drv_en_q); end
    checks++; if (rsp_valid0 !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %0b want 0", rsp_valid0); end
    checks++; if (rsp_data0 !== 8'h00) begin errors++; $display("FAIL rst_rsp_data: got %h want 00", rsp_data0); end
    checks++; if (rsp_err0 !== 1'b0) begin errors++; $display("FAIL rst_rsp_err: got %0b want 0", rsp_err0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", busy0); end
    checks++; if (req_ready0 !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %0b want 0", req_ready0); end
    n_reset = 1'b1;
    nedge();
    checks++; if (req_ready0 !== 1'b1) begin errors++; $display("FAIL idle_req_ready: got %0b want 1", req_ready0); end
    $display("reset: done");
  endtask

  task automatic test_add();
    req_cmd = CMD_ADD; req_a = 8'd1; req_b = 8'd5; req_valid0 = 1'b1;
    nedge();
    req_valid0 = 1'b0; req_a = 8'hAA; req_b = 8'h33; req_cmd = CMD_SUB;  // late changes must not matter
    checks++; if (op0 !== ALU_WRITE_R0) begin errors++; $display("FAIL add_op_wr0: got %0d want %0d", op0, ALU_WRITE_R0); end
    checks++; if (bus0 !== 8'd1) begin errors++; $display("FAIL add_bus_a: got %h want 01", bus0); end
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL add_busy: got %0b want 1", busy0); end
    checks++; if (req_ready0 !== 1'b0) begin errors++; $display("FAIL add_req_ready: got %0b want 0", req_ready0); end
    nedge();
    checks++; if (op0 !== ALU_WRITE_R1) begin errors++; $display("FAIL add_op_wr1: got %0d want %0d", op0, ALU_WRITE_R1); end
    checks++; if (bus0 !== 8'd5) begin errors++; $display("FAIL add_bus_b: got %h want 05", bus0); end
    nedge();
    checks++; if (op0 !== ALU_ADD) begin errors++; $display("FAIL add_op_exec: got %0d want %0d", op0, ALU_ADD); end
    checks++; if (dut0.drv_en_q !== 1'b0) begin errors++; $display("FAIL add_exec_released: got %0b want 0", dut0.drv_en_q); end
    checks++; if (bus0 !== 8'd6) begin errors++; $display("FAIL add_bus_result: got %h want 06", bus0); end
    checks++; if (rsp_valid0 !== 1'b0) begin errors++; $display("FAIL add_rsp_early: got %0b want 0", rsp_valid0); end
    nedge();
    checks++; if (rsp_valid0 !== 1'b1) begin errors++; $display("FAIL add_rsp_valid: got %0b want 1", rsp_valid0); end
    checks++; if (rsp_data0 !== 8'd6) begin errors++; $display("FAIL add_rsp_data: got %h want 06", rsp_data0); end
    checks++; if (rsp_err0 !== 1'b0) begin errors++; $display("FAIL add_rsp_err: got %0b want 0", rsp_err0); end
    checks++; if (op0 !== ALU_NOP) begin errors++; $display("FAIL add_op_done: got %0d want %0d", op0, ALU_NOP); end
    rsp_ready = 1'b1;
    nedge();
    rsp_ready = 1'b0;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL add_back_idle: got %0b want 0", busy0); end
    $display("add 01+05: rsp_data=%h", rsp_data0);
  endtask

  task automatic test_sub_inc();
    req_cmd = CMD_SUB; req_a = 8'd3; req_b = 8'd5; req_valid0 = 1'b1;
    nedge(); req_valid0 = 1'b0;
    nedge(); nedge(); nedge();
    checks++; if (rsp_valid0 !== 1'b1) begin errors++; $display("FAIL sub_rsp_valid: got %0b want 1", rsp_valid0); end
    checks++; if (rsp_data0 !== 8'hFE) begin errors++; $display("FAIL sub_rsp_data: got %h want fe", rsp_data0); end
    rsp_ready = 1'b1;
    nedge(); rsp_ready = 1'b0;
    $display("sub 03-05: done");
    req_cmd = CMD_INC; req_a = 8'hFF; req_b = 8'h77; req_valid0 = 1'b1;
    nedge(); req_valid0 = 1'b0;
    checks++; if (op0 !== ALU_WRITE_R0) begin errors++; $display("FAIL inc_op_wr0: got %0d want %0d", op0, ALU_WRITE_R0); end
    nedge();
    checks++; if (op0 !== ALU_INC) begin errors++; $display("FAIL inc_op_exec: got %0d want %0d", op0, ALU_INC); end
    checks++; if (bus0 !== 8'h00) begin errors++; $display("FAIL inc_bus_result: got %h want 00", bus0); end
    nedge();
    checks++; if (rsp_valid0 !== 1'b1) begin errors++; $display("FAIL inc_rsp_valid: got %0b want 1", rsp_valid0); end
    checks++; if (rsp_data0 !== 8'h00) begin errors++; $display("FAIL inc_rsp_data: got %h want 00", rsp_data0); end
    rsp_ready = 1'b1;
    nedge(); rsp_ready = 1'b0;
    $display("inc ff: done");
  endtask

  task automatic test_back_to_back();
    req_cmd = CMD_ADD; req_a = 8'h80; req_b = 8'h80; req_valid0 = 1'b1;
    nedge(); req_valid0 = 1'b0;
    nedge(); nedge();
    for (int i = 0; i < 5; i++) begin
      nedge();
      checks++; if (rsp_valid0 !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid[%0d]: got %0b want 1", i, rsp_valid0); end
      checks++; if (rsp_data0 !== 8'h00) begin errors++; $display("FAIL bp_rsp_data[%0d]: got %h want 00", i, rsp_data0); end
      checks++; if (req_ready0 !== 1'b0) begin errors++; $display("FAIL bp_req_ready[%0d]: got %0b want 0", i, req_ready0); end
      checks++; if (op0 !== ALU_NOP) begin errors++; $display("FAIL bp_op[%0d]: got %0d want %0d", i, op0, ALU_NOP); end
      checks++; if (dut0.drv_en_q !== 1'b0) begin errors++; $display("FAIL bp_drv_en[%0d]: got %0b want 0", i, dut0.drv_en_q); end
    end
    // Release and offer a new (reserved) request in the same cycle: it must not be taken then.
    rsp_ready = 1'b1; req_cmd = CMD_RSVD; req_valid0 = 1'b1;
    nedge(); rsp_ready = 1'b0;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy %0b want 0", busy0); end
    checks++; if (rsp_valid0 !== 1'b0) begin errors++; $display("FAIL b2b_rsp_cleared: got %0b want 0", rsp_valid0); end
    checks++; if (req_ready0 !== 1'b1) begin errors++; $display("FAIL b2b_req_ready: got %0b want 1", req_ready0); end
    nedge(); req_valid0 = 1'b0;
    checks++; if (rsp_valid0 !== 1'b1) begin errors++; $display("FAIL b2b_rsp_valid: got %0b want 1", rsp_valid0); end
    checks++; if (rsp_err0 !== 1'b1) begin errors++; $display("FAIL b2b_rsp_err: got %0b want 1", rsp_err0); end
    rsp_ready = 1'b1;
    nedge(); rsp_ready = 1'b0;
    $display("backpressure 80+80 then back-to-back reserved: done");
  endtask

  task automatic test_reserved();
    req_cmd = CMD_RSVD; req_a = 8'h55; req_b = 8'h66; req_valid0 = 1'b1;
    nedge(); req_valid0 = 1'b0;
    checks++; if (op0 !== ALU_NOP) begin errors++; $display("FAIL rsvd_op: got %0d want %0d", op0, ALU_NOP); end
    checks++; if (dut0.drv_en_q !== 1'b0) begin errors++; $display("FAIL rsvd_drv_en: got %0b want 0", dut0.drv_en_q); end
    checks++; if (rsp_valid0 !== 1'b1) begin errors++; $display("FAIL rsvd_rsp_valid: got %0b want 1", rsp_valid0); end
    checks++; if (rsp_data0 !== 8'h00) begin errors++; $display("FAIL rsvd_rsp_data: got %h want 00", rsp_data0); end
    checks++; if (rsp_err0 !== 1'b1) begin errors++; $display("FAIL rsvd_rsp_err: got %0b want 1", rsp_err0); end
    rsp_ready = 1'b1;
    nedge(); rsp_ready = 1'b0;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rsvd_idle: got busy %0b want 0", busy0); end
    $display("reserved cmd: done");
  endtask

  task automatic test_reset_mid();
    req_cmd = CMD_ADD; req_a = 8'd9; req_b = 8'd9; req_valid0 = 1'b1;
    nedge(); req_valid0 = 1'b0;
    @(posedge clock);   // sequencer enters WR1 here
    n_reset = 1'b0;
    nedge();
    checks++; if (op0 !== ALU_NOP) begin errors++; $display("FAIL mid_rst_op: got %0d want %0d", op0, ALU_NOP); end
    checks++; if (dut0.drv_en_q !== 1'b0) begin errors++; $display("FAIL mid_rst_drv_en: got %0b want 0", dut0.drv_en_q); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %0b want 0", busy0); end
    checks++; if (req_ready0 !== 1'b0) begin errors++; $display("FAIL mid_rst_req_ready: got %0b want 0", req_ready0); end
    nedge();
    checks++; if (rsp_valid0 !== 1'b0) begin errors++; $display("FAIL mid_rst_rsp_valid: got %0b want 0", rsp_valid0); end
    n_reset = 1'b1;
    nedge();
    req_cmd = CMD_ADD; req_a = 8'd2; req_b = 8'd2; req_valid0 = 1'b1;
    nedge(); req_valid0 = 1'b0;
    checks++; if (rsp_valid0 !== 1'b0) begin errors++; $display("FAIL post_rst_no_stale: got %0b want 0", rsp_valid0); end
    nedge(); nedge(); nedge();
    checks++; if (rsp_valid0 !== 1'b1) begin errors++; $display("FAIL post_rst_rsp_valid: got %0b want 1", rsp_valid0); end
    checks++; if (rsp_data0 !== 8'd4) begin errors++; $display("FAIL post_rst_rsp_data: got %h want 04", rsp_data0); end
    checks++; if (rsp_err0 !== 1'b0) begin errors++; $display("FAIL post_rst_rsp_err: got %0b want 0", rsp_err0); end
    rsp_ready = 1'b1;
    nedge(); rsp_ready = 1'b0;
    $display("reset mid-sequence then add 02+02: rsp_data=%h", rsp_data0);
  endtask

  task automatic test_turnaround();
    req_cmd = CMD_ADD; req_a = 8'd7; req_b = 8'd9; req_valid2 = 1'b1;
    nedge(); req_valid2 = 1'b0;
    checks++; if (op2 !== ALU_WRITE_R0) begin errors++; $display("FAIL ta_op_wr0: got %0d want %0d", op2, ALU_WRITE_R0); end
    nedge();
    checks++; if (op2 !== ALU_WRITE_R1) begin errors++; $display("FAIL ta_op_wr1: got %0d want %0d", op2, ALU_WRITE_R1); end
    checks++; if (bus2 !== 8'd9) begin errors++; $display("FAIL ta_bus_b: got %h want 09", bus2); end
    for (int i = 0; i < 2; i++) begin
      nedge();
      checks++; if (op2 !== ALU_NOP) begin errors++; $display("FAIL ta_turn_op[%0d]: got %0d want %0d", i, op2, ALU_NOP); end
      checks++; if (dut2.drv_en_q !== 1'b0) begin errors++; $display("FAIL ta_turn_drv_en[%0d]: got %0b want 0", i, dut2.drv_en_q); end
      checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL ta_turn_busy[%0d]: got %0b want 1", i, busy2); end
    end
    nedge();
    checks++; if (op2 !== ALU_ADD) begin errors++; $display("FAIL ta_op_exec: got %0d want %0d", op2, ALU_ADD); end
    checks++; if (rsp_valid2 !== 1'b0) begin errors++; $display("FAIL ta_rsp_early: got %0b want 0", rsp_valid2); end
    nedge();
    checks++; if (rsp_valid2 !== 1'b1) begin errors++; $display("FAIL ta_rsp_valid: got %0b want 1", rsp_valid2); end
    checks++; if (rsp_data2 !== 8'd16) begin errors++; $display("FAIL ta_rsp_data: got %h want 10", rsp_data2); end
    rsp_ready = 1'b1;
    nedge(); rsp_ready = 1'b0;
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL ta_idle: got %0b want 0", busy2); end
    $display("turnaround=2 add 07+09: rsp_data=%h", rsp_data2);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_inc();
    test_back_to_back();
    test_reserved();
    test_reset_mid();
    test_turnaround();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Initiator for the shared-bus ALU: accepts one arithmetic request at a time over a valid/ready handshake.
- Sequences the ALU op codes: write R0, write R1, then execute.
- Drives operands onto the shared 8-bit tri-state bus, then releases the bus so the ALU can drive its result, and captures that result.
- Returns the captured result on a valid/ready response port.
- Sits between the control path and the ALU/bus fabric.

Parameters:
- WIDTH, 8, bus/operand/result width.
- TURNAROUND, 0, idle cycles (op=ALU_NOP, bus released) inserted before EXEC; legal values 0..3.

Ports:
- clock  in  1  system clock, all state on rising edge
- n_reset  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid&&req_ready at rising edge
- req_cmd  in  2  seq_cmd_t: CMD_ADD=0, CMD_SUB=1, CMD_INC=2, 3 reserved
- req_a  in  WIDTH  operand A (to R0)
- req_b  in  WIDTH  operand B (to R1; ignored for INC)
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer takes result
- rsp_data  out  WIDTH  captured result
- rsp_err  out  1  reserved command flag, qualified by rsp_valid
- op  out  alu_op_t  op code to ALU
- bus  inout  WIDTH  shared tri-state data bus
- busy  out  1  high whenever state!=IDLE

Behaviour:
- Reset (async, n_reset low):
  - state=IDLE, op=ALU_NOP, bus released (all 'z from this block).
  - rsp_valid=0, rsp_data=0, rsp_err=0, busy=0.
  - req_ready=0 while n_reset low.
  - Takes effect immediately, including mid-sequence; an in-flight request is discarded with no response.
- States: IDLE, WR0, WR1, TURN, EXEC, DONE. op, bus drive enable and bus drive data are registered.
- IDLE:
  - req_ready=1, op=ALU_NOP, bus released.
  - On accept: latch cmd/a/b.
  - Reserved cmd -> DONE directly with rsp_data=0, rsp_err=1, no bus activity.
  - Otherwise -> WR0.
- WR0 (1 cycle): op=ALU_WRITE_R0, drive latched a. Next: WR1 for ADD/SUB; for INC, TURN if TURNAROUND>0 else EXEC.
- WR1 (1 cycle): op=ALU_WRITE_R1, drive latched b. Next: TURN if TURNAROUND>0 else EXEC.
- TURN (TURNAROUND cycles, down-counter): op=ALU_NOP, bus released. Then EXEC.
- EXEC (1 cycle):
  - op=ALU_ADD / ALU_SUB / ALU_INC, bus released.
  - Bus sampled at the closing rising edge into rsp_data; rsp_err=0.
  - Next: DONE.
- DONE:
  - rsp_valid=1, op=ALU_NOP, bus released.
  - rsp_data/rsp_err held stable until rsp_ready.
  - On rsp_ready -> IDLE.
  - No same-cycle new accept; next accept is earliest one cycle after the handshake.
- Latency, accept edge to rsp_valid high:
  - ADD/SUB: 3+TURNAROUND cycles.
  - INC: 2+TURNAROUND cycles.
  - Reserved: 1 cycle.
- Arithmetic is performed by the ALU; results are modulo 2^WIDTH, with no carry/borrow output.
- Bus ownership rule: this block drives only in WR0/WR1. Any cycle with op in {NOP, ADD, SUB, INC} has this block released. Never drives in the same cycle as an ALU result op.
- req_a/req_b/req_cmd changes after the accept edge have no effect.

Decomposition:
- Shared package, existing ALU package: alu_op_t (ALU_NOP, ALU_WRITE_R0, ALU_WRITE_R1, ALU_ADD, ALU_SUB, ALU_INC). Add seq_cmd_t and the state enum seq_state_t there.
- Sub-module: reuse existing tri_buf (WIDTH param) for the bus driver, with rw = registered drive enable and data = registered drive data.
- The FSM and latches stay in alu_sequencer.

Test Plan (bench instantiates alu_sequencer + real alu on one bus, clock period 2 ns):
- ADD a=1, b=5, TURNAROUND=0 -> op sequence WRITE_R0, WRITE_R1, ADD, NOP; bus=1, 5, then ALU-driven 6; rsp_valid 3 cycles after accept, rsp_data=6, rsp_err=0.
- SUB a=3, b=5 -> rsp_data=0xFE; then INC a=0xFF -> WRITE_R1 never issued, rsp_data=0x00 after 2 cycles.
- Backpressure: rsp_ready=0 for 5 cycles after ADD 0x80+0x80 -> rsp_valid held, rsp_data=0x00 stable, req_ready=0, op=NOP, bus 'z from sequencer; release -> IDLE next cycle.
- Reset mid-sequence: drop n_reset during WR1 -> immediately op=NOP, bus 'z, busy=0, no rsp_valid; after release, ADD 2+2 returns 4.
- TURNAROUND=2 build, ADD 7+9 -> two NOP/'z cycles between WRITE_R1 and ADD; rsp_valid at 5 cycles, rsp_data=16.
- Reserved cmd=3 -> no bus drive, op stays NOP, rsp_valid after 1 cycle with rsp_data=0, rsp_err=1.
